// File: rtl/dl_path_gain_tdm.sv
// Downlink per-antenna complex gain for a TDM-interleaved NCH-channel stream.
// Double-buffered gain banks commit on frame header; 4-cycle fixed latency.
module dl_path_gain_tdm #(
    parameter int NCH   = 8,
    parameter int DW    = 16,
    parameter int GW    = 16,
    parameter int GFRAC = 14,
    parameter int AW    = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            asy_rst,
    input  logic            i_gain_wr,
    input  logic [AW-1:0]   i_gain_addr,
    input  logic [2*GW-1:0] i_gain_data,
    input  logic            i_bypass,
    input  logic            i_fram_hd,
    input  logic            i_ant8_sel,
    input  logic [2*DW-1:0] i_data,
    input  logic            i_data_valid,
    output logic            o_fram_hd,
    output logic            o_ant8_sel,
    output logic [2*DW-1:0] o_data,
    output logic            o_data_valid,
    output logic            o_sat,
    output logic [15:0]     o_sat_cnt
);

    localparam int PW = DW + GW;
    localparam int SW = PW + 1;
    localparam logic [GW-1:0]         G_ONE = GW'(2 ** GFRAC);
    localparam logic [2*GW-1:0]       UNITY = {G_ONE, {GW{1'b0}}};
    localparam logic signed [SW-1:0]  MAXV  = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0]  MINV  = ~MAXV;
    localparam logic signed [SW-1:0]  RND   = SW'(2 ** (GFRAC - 1));

    logic [2*GW-1:0] pend_q [NCH];
    logic [2*GW-1:0] pend_d [NCH];
    logic [2*GW-1:0] act_q  [NCH];
    logic [AW-1:0]   ch_q, ch_d, ch_cur;
    logic            commit;
    logic [2*GW-1:0] gain_sel;

    // A write landing on the header cycle is folded into the commit.
    always_comb begin
        pend_d = pend_q;
        if (i_gain_wr && (int'(i_gain_addr) < NCH))
            pend_d[i_gain_addr] = i_gain_data;
    end

    assign commit   = i_data_valid & i_fram_hd;
    assign ch_cur   = i_fram_hd ? '0 : ch_q;
    assign gain_sel = commit ? pend_d[0] : act_q[ch_q];

    always_comb begin
        ch_d = ch_q;
        if (i_data_valid)
            ch_d = (ch_cur == AW'(NCH - 1)) ? '0 : ch_cur + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (asy_rst) begin
            ch_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                pend_q[k] <= UNITY;
                act_q[k]  <= UNITY;
            end
        end else begin
            ch_q   <= ch_d;
            pend_q <= pend_d;
            if (commit)
                act_q <= pend_d;
        end
    end

    logic            s1_vld_q, s1_hd_q, s1_a8_q, s1_byp_q;
    logic [2*DW-1:0] s1_dat_q;
    logic [2*GW-1:0] s1_gain_q;
    logic            s2_vld_q, s2_hd_q, s2_a8_q, s2_byp_q;
    logic [2*DW-1:0] s2_dat_q;
    logic signed [PW-1:0] s2_ac_q, s2_bd_q, s2_ad_q, s2_bc_q;
    logic signed [PW-1:0] ac_d, bd_d, ad_d, bc_d;
    logic            s3_vld_q, s3_hd_q, s3_a8_q, s3_byp_q;
    logic [2*DW-1:0] s3_dat_q;
    logic signed [SW-1:0] s3_re_q, s3_im_q, re_d, im_d;
    logic signed [DW-1:0] a_s, b_s;
    logic signed [GW-1:0] c_s, d_s;

    assign a_s = s1_dat_q[2*DW-1:DW];
    assign b_s = s1_dat_q[DW-1:0];
    assign c_s = s1_gain_q[2*GW-1:GW];
    assign d_s = s1_gain_q[GW-1:0];

    assign ac_d = PW'(a_s) * PW'(c_s);
    assign bd_d = PW'(b_s) * PW'(d_s);
    assign ad_d = PW'(a_s) * PW'(d_s);
    assign bc_d = PW'(b_s) * PW'(c_s);
    assign re_d = SW'(s2_ac_q) - SW'(s2_bd_q);
    assign im_d = SW'(s2_ad_q) + SW'(s2_bc_q);

    logic signed [SW-1:0] rnd_re, rnd_im, sh_re, sh_im;
    logic                 clip_re, clip_im, sat_d;
    logic [DW-1:0]        res_re, res_im;
    logic [2*DW-1:0]      dat_d;

    always_comb begin
        rnd_re  = s3_re_q + RND;
        rnd_im  = s3_im_q + RND;
        sh_re   = rnd_re >>> GFRAC;
        sh_im   = rnd_im >>> GFRAC;
        clip_re = (sh_re > MAXV) || (sh_re < MINV);
        clip_im = (sh_im > MAXV) || (sh_im < MINV);
        res_re  = sh_re[DW-1:0];
        res_im  = sh_im[DW-1:0];
        if (clip_re)
            res_re = sh_re[SW-1] ? MINV[DW-1:0] : MAXV[DW-1:0];
        if (clip_im)
            res_im = sh_im[SW-1] ? MINV[DW-1:0] : MAXV[DW-1:0];
        dat_d = s3_byp_q ? s3_dat_q : {res_re, res_im};
        sat_d = s3_vld_q & ~s3_byp_q & (clip_re | clip_im);
    end

    logic [15:0] run_q;

    always_ff @(posedge clk) begin
        if (asy_rst) begin
            s1_vld_q <= 1'b0; s1_hd_q <= 1'b0; s1_a8_q <= 1'b0;
            s1_byp_q <= 1'b0; s1_dat_q <= '0; s1_gain_q <= '0;
            s2_vld_q <= 1'b0; s2_hd_q <= 1'b0; s2_a8_q <= 1'b0;
            s2_byp_q <= 1'b0; s2_dat_q <= '0;
            s2_ac_q <= '0; s2_bd_q <= '0; s2_ad_q <= '0; s2_bc_q <= '0;
            s3_vld_q <= 1'b0; s3_hd_q <= 1'b0; s3_a8_q <= 1'b0;
            s3_byp_q <= 1'b0; s3_dat_q <= '0;
            s3_re_q <= '0; s3_im_q <= '0;
            o_data_valid <= 1'b0; o_fram_hd <= 1'b0; o_ant8_sel <= 1'b0;
            o_data <= '0; o_sat <= 1'b0;
            o_sat_cnt <= '0; run_q <= '0;
        end else begin
            s1_vld_q  <= i_data_valid;
            s1_hd_q   <= i_fram_hd;
            s1_a8_q   <= i_ant8_sel;
            s1_byp_q  <= i_bypass;
            s1_dat_q  <= i_data;
            s1_gain_q <= gain_sel;
            s2_vld_q <= s1_vld_q; s2_hd_q <= s1_hd_q; s2_a8_q <= s1_a8_q;
            s2_byp_q <= s1_byp_q; s2_dat_q <= s1_dat_q;
            s2_ac_q <= ac_d; s2_bd_q <= bd_d; s2_ad_q <= ad_d; s2_bc_q <= bc_d;
            s3_vld_q <= s2_vld_q; s3_hd_q <= s2_hd_q; s3_a8_q <= s2_a8_q;
            s3_byp_q <= s2_byp_q; s3_dat_q <= s2_dat_q;
            s3_re_q <= re_d; s3_im_q <= im_d;
            o_data_valid <= s3_vld_q;
            o_fram_hd    <= s3_hd_q;
            o_ant8_sel   <= s3_a8_q;
            o_data       <= dat_d;
            o_sat        <= sat_d;
            // Header output closes the previous frame's tally.
            if (s3_vld_q && s3_hd_q) begin
                o_sat_cnt <= run_q;
                run_q     <= {15'd0, sat_d};
            end else if (sat_d && (run_q != 16'hFFFF)) begin
                run_q <= run_q + 16'd1;
            end
        end
    end

endmodule

// File: doc/dl_path_gain_tdm.md
Name: dl_path_gain_tdm

Overview:
- Parametrised successor of the downlink per-antenna power stage.
- Applies a programmable complex gain to a TDM-interleaved stream of NCH antenna channels.
- Multiplier is in-fabric RTL with round-half-up and saturation. Gain banks are double-buffered and commit only on frame header.
- Sits between the downlink path data source and the antenna mapper. It forwards frame header and ant8_sel aligned to data.

Parameters:
- NCH, 8, antenna channels interleaved per TDM cycle (2..16, any integer).
- DW, 16, signed width of each I and Q data component.
- GW, 16, signed width of each I and Q gain component.
- GFRAC, 14, fractional bits of gain; unity gain = 2^GFRAC.
- AW, $clog2(NCH), channel index width.

Ports:
- clk  in  1  system clock
- asy_rst  in  1  reset; synchronous, active-high despite the name
- i_gain_wr  in  1  gain write strobe
- i_gain_addr  in  AW  channel index for the write
- i_gain_data  in  2*GW  {gain I, gain Q}
- i_bypass  in  1  1 = pass data unmodified
- i_fram_hd  in  1  frame header; marks channel 0 of a frame
- i_ant8_sel  in  1  sideband, delayed with data
- i_data  in  2*DW  {I[2DW-1:DW], Q[DW-1:0]}
- i_data_valid  in  1  sample valid
- o_fram_hd  out  1  aligned frame header
- o_ant8_sel  out  1  aligned sideband
- o_data  out  2*DW  {I, Q} result
- o_data_valid  out  1  aligned valid
- o_sat  out  1  result for this sample was clipped
- o_sat_cnt  out  16  clipped-sample count of the last completed frame

Behaviour:
- Reset:
  - All outputs are 0.
  - Pipeline valids are cleared; in-flight samples are discarded with no output.
  - Channel counter is 0.
  - Both gain banks are unity ({2^GFRAC, 0}) for every channel.
  - Internal sat counter is 0.
- Channel counter (ch):
  - Advances only on i_data_valid.
  - On valid with i_fram_hd=1, the sample is channel 0 and the next sample is channel 1.
  - Otherwise ch wraps from NCH-1 to 0.
  - Invalid cycles hold ch.
- Gain banks:
  - Writes go to the pending bank only. i_gain_addr >= NCH is ignored.
  - On valid with i_fram_hd=1, pending is copied to active. A write in the same cycle is included in the copy.
  - The header sample itself already uses the newly committed gains.
- Pipeline, fixed latency 4 cycles from input to output for data, valid, fram_hd, ant8_sel, and bypass (every path):
  - S1: register data, sidebands, bypass, and the active gain[ch].
  - S2: four products ac, bd, ad, bc, each DW+GW bits signed.
  - S3: re = ac - bd; im = ad + bc; width DW+GW+1.
  - S4: add 2^(GFRAC-1), arithmetic shift right by GFRAC, saturate to [-2^(DW-1), 2^(DW-1)-1] per component.
- o_sat:
  - 1 if either component clipped in S4.
  - Forced 0 when bypass is set or valid is 0.
- Bypass: o_data equals the input data 4 cycles earlier, bit-exact.
- Invalid samples still propagate. o_data is don't-care when o_data_valid=0, and gain is not applied for such cycles.
- o_sat_cnt:
  - Counts valid clipped outputs, saturating at 0xFFFF.
  - On an output with o_fram_hd=1 and valid, o_sat_cnt latches the running count. The running count then restarts at o_sat of that sample.
- Simultaneous header and wrap: the header always wins, forcing ch=0.

Test Plan:
- Reset, then feed 16 valid samples with fram_hd on the first and default gains. o_data equals input after exactly 4 cycles, o_sat=0, and ch 0..7 repeats twice.
- Write ch0 gain {8192,0} and assert a header. Input I=1000, Q=-500 on ch0 gives I=500, Q=-250. Input I=3 gives 2 (1.5 rounded up); I=-3 gives -1.
- Write ch3 gain {16384,16384}. Input I=32767, Q=32767 on ch3 after the next header gives I=0, Q=32767 with o_sat=1. At the following header, o_sat_cnt=1.
- Write ch2 = {0,16384} mid-frame. Ch2 in the current frame stays unity; after the next header, input (100,50) gives (-50,100). A write coincident with the header is effective on that frame.
- Set i_bypass=1 with non-unity gains and random data. Output is bit-exact to input at 4 cycles latency and o_sat=0. Toggle bypass per sample; each sample follows its own bypass bit.
- Gapped valids: deassert valid for 3 cycles mid-frame. ch holds and the channel order is preserved. Assert asy_rst mid-stream: the next cycle all outputs are 0, gains are unity, and no stale valids emerge.
